// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: program counter, IF/ID decode register,
// hazard-unit stall handshake, execute redirects and saturating statistics.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             reg_en,
    input  logic             hzd_out,
    output logic             hzd_q,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      decode_ir,
    output logic [31:0]      decode_pc,
    output logic             decode_valid,
    output logic             pc_misaligned,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      decode_ir_q, decode_ir_d;
    logic [31:0]      decode_pc_q, decode_pc_d;
    logic             decode_valid_q, decode_valid_d;
    logic             hzd_d;
    logic             pc_misaligned_q, pc_misaligned_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Redirect beats any stall; the PC only advances when the word is captured.
    always_comb begin
        pc_d            = pc_q;
        decode_ir_d     = decode_ir_q;
        decode_pc_d     = decode_pc_q;
        decode_valid_d  = decode_valid_q;
        pc_misaligned_d = pc_misaligned_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        hzd_d           = hzd_out;

        if (redirect) begin
            pc_d           = {redirect_pc[31:2], 2'b00};
            decode_ir_d    = NOP;
            decode_valid_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                pc_misaligned_d = 1'b1;
            end
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else if (reg_en && pc_write) begin
            decode_ir_d    = imem_rdata;
            decode_pc_d    = pc_q;
            decode_valid_d = 1'b1;
            pc_d           = pc_q + 32'd4;
        end else if (reg_en) begin
            decode_ir_d    = NOP;
            decode_valid_d = 1'b0;
        end

        if (hzd_out && !redirect && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= RESET_VEC;
            decode_ir_q     <= NOP;
            decode_pc_q     <= RESET_VEC;
            decode_valid_q  <= 1'b0;
            hzd_q           <= 1'b0;
            pc_misaligned_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            pc_q            <= pc_d;
            decode_ir_q     <= decode_ir_d;
            decode_pc_q     <= decode_pc_d;
            decode_valid_q  <= decode_valid_d;
            hzd_q           <= hzd_d;
            pc_misaligned_q <= pc_misaligned_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign imem_addr     = pc_q;
    assign decode_ir     = decode_ir_q;
    assign decode_pc     = decode_pc_q;
    assign decode_valid  = decode_valid_q;
    assign pc_misaligned = pc_misaligned_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: directed vector table, counter saturation and
// async reset sequences, then random traffic against a behavioural model.
module tb_otter_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_write, reg_en, hzd_out, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] tb_word;
    logic        use_mem;

    logic [31:0] imem_addr, imem_rdata, decode_ir, decode_pc;
    logic        hzd_q, decode_valid, pc_misaligned;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_imem_addr, s_imem_rdata, s_decode_ir, s_decode_pc;
    logic        s_hzd_q, s_decode_valid, s_pc_misaligned;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int fails  = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata   = use_mem ? memword(imem_addr)   : tb_word;
    assign s_imem_rdata = use_mem ? memword(s_imem_addr) : tb_word;

    otter_fetch_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .reg_en(reg_en),
        .hzd_out(hzd_out), .hzd_q(hzd_q), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .decode_ir(decode_ir),
        .decode_pc(decode_pc), .decode_valid(decode_valid),
        .pc_misaligned(pc_misaligned), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    otter_fetch_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .pc_write(pc_write), .reg_en(reg_en),
        .hzd_out(hzd_out), .hzd_q(s_hzd_q), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .decode_ir(s_decode_ir),
        .decode_pc(s_decode_pc), .decode_valid(s_decode_valid),
        .pc_misaligned(s_pc_misaligned), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        pw, re, hz, rd;
        logic [31:0] rpc, word;
        logic [31:0] e_addr, e_ir, e_pc;
        logic        e_v, e_hq, e_mis;
        int          e_s, e_f;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: counters kept as unbounded totals.
    logic [31:0] m_pc, m_ir, m_dpc;
    logic        m_v, m_hq, m_mis;
    int          m_stalls, m_flushes;

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satAt(input int total, input int maxv);
        return (total > maxv) ? maxv : total;
    endfunction

    task automatic applyStimulus(input logic pw, input logic re, input logic hz,
                                 input logic rd, input logic [31:0] rpc,
                                 input logic [31:0] word);
        pc_write    = pw;
        reg_en      = re;
        hzd_out     = hz;
        redirect    = rd;
        redirect_pc = rpc;
        tb_word     = word;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_addr,
                               input logic [31:0] e_ir, input logic [31:0] e_pc,
                               input logic e_v, input logic e_hq, input logic e_mis,
                               input int e_s, input int e_f);
        checkVal({tag, ".imem_addr"},     imem_addr,     e_addr);
        checkVal({tag, ".decode_ir"},     decode_ir,     e_ir);
        checkVal({tag, ".decode_pc"},     decode_pc,     e_pc);
        checkVal({tag, ".decode_valid"},  {31'd0, decode_valid},  {31'd0, e_v});
        checkVal({tag, ".hzd_q"},         {31'd0, hzd_q},         {31'd0, e_hq});
        checkVal({tag, ".pc_misaligned"}, {31'd0, pc_misaligned}, {31'd0, e_mis});
        checkVal({tag, ".stall_cnt"},     {16'd0, stall_cnt}, satAt(e_s, 65535));
        checkVal({tag, ".flush_cnt"},     {16'd0, flush_cnt}, satAt(e_f, 65535));
        checkVal({tag, ".sat_stall_cnt"}, {28'd0, s_stall_cnt}, satAt(e_s, 15));
        checkVal({tag, ".sat_flush_cnt"}, {28'd0, s_flush_cnt}, satAt(e_f, 15));
        checkVal({tag, ".sat_imem_addr"}, s_imem_addr, e_addr);
    endtask

    task automatic modelReset();
        m_pc = 32'h0; m_ir = NOP; m_dpc = 32'h0; m_v = 1'b0; m_hq = 1'b0;
        m_mis = 1'b0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        pc_write = 1'b0; reg_en = 1'b0; hzd_out = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; tb_word = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // One clock of the pipeline rules applied to the model.
    task automatic modelStep(input logic pw, input logic re, input logic hz,
                             input logic rd, input logic [31:0] rpc);
        logic [31:0] fetched;
        fetched = memword(m_pc);
        if (rd) begin
            m_pc = rpc & ~32'd3;
            m_ir = NOP;
            m_v  = 1'b0;
            if (rpc % 4 != 0) m_mis = 1'b1;
            m_flushes++;
        end else if (pw && re) begin
            m_ir  = fetched;
            m_dpc = m_pc;
            m_v   = 1'b1;
            m_pc  = m_pc + 32'd4;
        end else if (re) begin
            m_ir = NOP;
            m_v  = 1'b0;
        end
        if (hz && !rd) m_stalls++;
        m_hq = hz;
    endtask

    function automatic vec_t mk(input logic pw, input logic re, input logic hz,
                                input logic rd, input logic [31:0] rpc,
                                input logic [31:0] word, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic ev, input logic eh, input logic em,
                                input int es, input int ef);
        vec_t v;
        v.pw = pw; v.re = re; v.hz = hz; v.rd = rd; v.rpc = rpc; v.word = word;
        v.e_addr = ea; v.e_ir = ei; v.e_pc = ep; v.e_v = ev; v.e_hq = eh;
        v.e_mis = em; v.e_s = es; v.e_f = ef;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        use_mem = 1'b0;
        pc_write = 1'b0; reg_en = 1'b0; hzd_out = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; tb_word = 32'h0;

        //            pw re hz rd rpc           word     | addr          ir         pc            v  hq mis s  f
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h11,  32'h4,        32'h11,  32'h0,        1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h22,  32'h8,        32'h22,  32'h4,        1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h33,  32'h8,        32'h22,  32'h4,        1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h33,  32'h8,        32'h22,  32'h4,        1, 1, 0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h33,  32'h8,        NOP,     32'h4,        0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h33,  32'hC,        32'h33,  32'h8,        1, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h44,  32'h10,       32'h44,  32'hC,        1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h100,      32'h55,  32'h100,      NOP,     32'hC,        0, 1, 0, 2, 1));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h500, 32'h104,      32'h500, 32'h100,      1, 0, 0, 2, 1));
        vecs.push_back(mk(1, 1, 0, 1, 32'h203,      32'h66,  32'h200,      NOP,     32'h100,      0, 0, 1, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h600, 32'h204,      32'h600, 32'h200,      1, 0, 1, 2, 2));
        vecs.push_back(mk(1, 1, 1, 1, 32'h300,      32'h77,  32'h300,      NOP,     32'h200,      0, 1, 1, 2, 3));
        vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h88, 32'hFFFF_FFFC, NOP,    32'h200,      0, 0, 1, 2, 4));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h777, 32'h0,        32'h777, 32'hFFFF_FFFC, 1, 0, 1, 2, 4));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        32'h999, 32'h0,        32'h777, 32'hFFFF_FFFC, 1, 1, 1, 3, 4));

        doReset();
        checkOutput("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pw, vecs[i].re, vecs[i].hz, vecs[i].rd,
                          vecs[i].rpc, vecs[i].word);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ir,
                        vecs[i].e_pc, vecs[i].e_v, vecs[i].e_hq, vecs[i].e_mis,
                        vecs[i].e_s, vecs[i].e_f);
        end

        // Long stall: the 4-bit counter must stick at 15 while 16-bit keeps going.
        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hAB);
        checkOutput("stall_sat", 32'h0, NOP, 32'h0, 1'b0, 1'b1, 1'b0, 20, 0);

        // Repeated misaligned redirects saturate the flush counter.
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h41, 32'hAB);
        checkOutput("flush_sat", 32'h40, NOP, 32'h0, 1'b0, 1'b0, 1'b1, 20, 20);

        // Reset asserted between edges during a stall must act immediately.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hAB);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        use_mem = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic pw, re, hz, rd;
            logic [31:0] rpc;
            pw  = ($urandom_range(0, 3) != 0);
            re  = ($urandom_range(0, 4) != 0);
            hz  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            modelStep(pw, re, hz, rd, rpc);
            applyStimulus(pw, re, hz, rd, rpc, 32'h0);
            checkOutput($sformatf("rand%0d", i), m_pc, m_ir, m_dpc, m_v, m_hq,
                        m_mis, m_stalls, m_flushes);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
